// File: rtl/video_pkg.sv
// Shared types and constants for the video block's CPU-side helpers.
package video_pkg;

  // Sprite DMA sequencer states
  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  // PPU register index of OAMDATA
  localparam logic [2:0]  PPU_REG_OAMDATA = 3'd4;
  // CPU address whose write launches a sprite DMA
  localparam logic [15:0] CPU_ADDR_OAMDMA = 16'h4014;
  // Bytes moved per transfer
  localparam int          DMA_LENGTH      = 256;

endpackage

// File: rtl/oam_dma_if.sv
// Bundle of CPU snoop, DMA bus and PPU host-port signals around the sprite DMA.
// master = the DMA engine, slave = the surrounding system (CPU, arbiter, PPU).
interface oam_dma_if;

  logic        I_tick;
  logic [15:0] I_cpu_addr;
  logic        I_cpu_wren;
  logic [7:0]  I_cpu_data;
  logic        I_cpu_rdcyc;
  logic        O_cpu_halt;
  logic [15:0] O_bus_addr;
  logic        O_bus_rden;
  logic [7:0]  I_bus_data;
  logic [2:0]  O_ppu_addr;
  logic        O_ppu_wren;
  logic [7:0]  O_ppu_data;
  logic        O_busy;

  modport master (
    input  I_tick, I_cpu_addr, I_cpu_wren, I_cpu_data, I_cpu_rdcyc, I_bus_data,
    output O_cpu_halt, O_bus_addr, O_bus_rden, O_ppu_addr, O_ppu_wren, O_ppu_data, O_busy
  );

  modport slave (
    output I_tick, I_cpu_addr, I_cpu_wren, I_cpu_data, I_cpu_rdcyc, I_bus_data,
    input  O_cpu_halt, O_bus_addr, O_bus_rden, O_ppu_addr, O_ppu_wren, O_ppu_data, O_busy
  );

endinterface

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: a CPU write to the trigger address halts the CPU and
// copies one CPU page into PPU OAMDATA, alternating read and write CPU cycles.
module oam_dma
  import video_pkg::*;
#(
  parameter logic [15:0] P_trigger_addr = CPU_ADDR_OAMDMA,
  parameter logic [2:0]  P_oam_reg      = PPU_REG_OAMDATA,
  parameter int          P_length       = DMA_LENGTH
) (
  input  logic           I_clock,
  input  logic           I_reset,
  oam_dma_if.master      io
);

  // Index value of the final byte; transfers shorter than a page end early.
  localparam logic [7:0] LAST_INDEX = 8'(P_length - 1);

  dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] byte_q, byte_d;
  logic       parity_q, parity_d;

  // State register with asynchronous active-low reset
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q  <= IDLE;
      page_q   <= '0;
      index_q  <= '0;
      byte_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      byte_q   <= byte_d;
      parity_q <= parity_d;
    end
  end

  // Next-state logic; everything holds unless a CPU cycle strobe is present
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    byte_d   = byte_q;
    parity_d = parity_q;
    if (io.I_tick) begin
      parity_d = ~parity_q;
      case (state_q)
        IDLE: begin
          if (io.I_cpu_wren && (io.I_cpu_addr == P_trigger_addr)) begin
            page_d  = io.I_cpu_data;
            index_d = '0;
            state_d = HALT;
          end
        end
        // Wait until the CPU is really stopped (a read cycle); then make
        // sure the first read lands on an even cycle.
        HALT: begin
          if (io.I_cpu_rdcyc) begin
            state_d = parity_q ? READ : ALIGN;
          end
        end
        ALIGN: state_d = READ;
        READ: begin
          byte_d  = io.I_bus_data;
          state_d = WRITE;
        end
        WRITE: begin
          index_d = index_q + 8'd1;
          state_d = (index_q == LAST_INDEX) ? IDLE : READ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state; the PPU strobe is gated by the tick
  // so it is one clock wide and never fires between CPU cycles.
  always_comb begin
    io.O_busy     = (state_q != IDLE);
    io.O_cpu_halt = (state_q != IDLE);
    io.O_bus_rden = (state_q == READ);
    io.O_bus_addr = io.O_bus_rden ? {page_q, index_q} : 16'h0000;
    io.O_ppu_wren = (state_q == WRITE) && io.I_tick;
    io.O_ppu_addr = io.O_ppu_wren ? P_oam_reg : 3'd0;
    io.O_ppu_data = io.O_ppu_wren ? byte_q : 8'h00;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomised bench for oam_dma: CPU cycle strobes with random gaps, a CPU
// memory image, and a transfer-level model of reads, writes and stall length.
module tb_oam_dma;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oam_dma_if io();

  oam_dma dut (
    .I_clock (clk),
    .I_reset (rst_n),
    .io      (io)
  );

  logic [7:0] mem [0:65535];
  assign io.I_bus_data = mem[io.O_bus_addr];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          tick_cnt = 0;
  int          halt_cnt = 0;
  int          first_rd_par = -1;
  logic [15:0] rd_q [$];
  logic [7:0]  wr_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus observer: logs every DMA read and PPU write seen on a CPU cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      tick_cnt = 0;
    end else begin
      check("wren_without_tick", {31'd0, io.O_ppu_wren & ~io.I_tick}, 32'd0);
      if (io.I_tick) begin
        if (io.O_cpu_halt) halt_cnt++;
        if (io.O_bus_rden) begin
          if (rd_q.size() == 0) first_rd_par = tick_cnt % 2;
          check("read_after_prev_write", {24'd0, io.O_bus_addr[7:0]}, 32'(wr_q.size() % 256));
          rd_q.push_back(io.O_bus_addr);
        end
        if (io.O_ppu_wren) begin
          check("ppu_reg_index", {29'd0, io.O_ppu_addr}, 32'd4);
          wr_q.push_back(io.O_ppu_data);
        end
        tick_cnt++;
      end
    end
  end

  // One CPU cycle: random idle clocks, then a single-clock tick with the given bus values
  task automatic do_tick(input logic [15:0] a, input logic w, input logic [7:0] d, input logic rd);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(posedge clk);
    #1;
    io.I_tick      = 1'b1;
    io.I_cpu_addr  = a;
    io.I_cpu_wren  = w;
    io.I_cpu_data  = d;
    io.I_cpu_rdcyc = rd;
    @(posedge clk);
    #1;
    io.I_tick     = 1'b0;
    io.I_cpu_wren = 1'b0;
  endtask

  task automatic pad_to(input int par);
    while ((tick_cnt % 2) != par) do_tick(16'h0000, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {31'd0, io.O_busy}, 32'd0);
    check({tag, "_halt"}, {31'd0, io.O_cpu_halt}, 32'd0);
    check({tag, "_rden"}, {31'd0, io.O_bus_rden}, 32'd0);
    check({tag, "_busaddr"}, {16'd0, io.O_bus_addr}, 32'd0);
    check({tag, "_ppuwren"}, {31'd0, io.O_ppu_wren}, 32'd0);
  endtask

  // Full transfer of page v: hold = CPU write cycles before the halt takes,
  // retrig = issue a second trigger write once 40 bytes have been read.
  task automatic run_dma(input logic [7:0] v, input int hold, input bit retrig);
    int  h0, align, n, exp_halt;
    bit  retrig_done;
    rd_q.delete();
    wr_q.delete();
    first_rd_par = -1;
    h0 = halt_cnt;
    // deciding HALT tick is the (hold+1)-th tick after the trigger
    align = (((tick_cnt + hold + 1) % 2) == 0) ? 1 : 0;
    exp_halt = hold + 1 + align + 2 * 256;
    do_tick(16'h4014, 1'b1, v, 1'b0);
    check("busy_after_trigger", {31'd0, io.O_busy}, 32'd1);
    check("halt_after_trigger", {31'd0, io.O_cpu_halt}, 32'd1);
    repeat (hold) do_tick(16'h0000, 1'b0, 8'h00, 1'b0);
    if (hold > 0) begin
      check("halt_wait_no_read", 32'(rd_q.size()), 32'd0);
      check("halt_wait_rden", {31'd0, io.O_bus_rden}, 32'd0);
    end
    n = 0;
    retrig_done = 1'b0;
    while (io.O_busy && n < 800) begin
      if (retrig && !retrig_done && rd_q.size() == 40) begin
        do_tick(16'h4014, 1'b1, ~v, 1'b1);
        retrig_done = 1'b1;
      end else begin
        do_tick(16'h0000, 1'b0, 8'h00, 1'b1);
      end
      n++;
    end
    check_quiet("done");
    check("halted_ticks", 32'(halt_cnt - h0), 32'(exp_halt));
    check("read_count", 32'(rd_q.size()), 32'd256);
    check("write_count", 32'(wr_q.size()), 32'd256);
    check("first_read_even", 32'(first_rd_par), 32'd0);
    for (int k = 0; k < 256; k++) begin
      if (k < rd_q.size()) check("read_addr", {16'd0, rd_q[k]}, {16'd0, v, 8'(k)});
      if (k < wr_q.size()) check("oam_data", {24'd0, wr_q[k]}, {24'd0, mem[{v, 8'(k)}]});
    end
    $display("dma page=%02h hold=%0d align=%0d retrig=%0d halted=%0d reads=%0d writes=%0d",
             v, hold, align, retrig, halt_cnt - h0, rd_q.size(), wr_q.size());
  endtask

  initial begin
    io.I_tick      = 1'b0;
    io.I_cpu_addr  = 16'h0000;
    io.I_cpu_wren  = 1'b0;
    io.I_cpu_data  = 8'h00;
    io.I_cpu_rdcyc = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i) ^ 8'h5A;

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;

    // odd deciding tick: no align
    pad_to(0);
    run_dma(8'h02, 0, 1'b0);
    // even deciding tick: one align cycle
    pad_to(1);
    run_dma(8'h02, 0, 1'b0);
    // CPU still writing for two cycles
    run_dma(8'h02, 2, 1'b0);
    // top page, fixed pattern
    run_dma(8'hFF, 0, 1'b0);
    check("ff_last_addr", {16'd0, rd_q[255]}, 32'h0000FFFF);
    check("ff_last_data", {24'd0, wr_q[255]}, 32'h000000A5);
    // retrigger mid-transfer is ignored
    run_dma(8'h31, 1, 1'b1);

    // reset in the middle of a transfer
    rd_q.delete();
    wr_q.delete();
    do_tick(16'h4014, 1'b1, 8'h77, 1'b1);
    for (int n = 0; n < 400 && rd_q.size() < 100; n++) do_tick(16'h0000, 1'b0, 8'h00, 1'b1);
    check("reached_index_100", 32'(rd_q.size()), 32'd100);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("reset asserted at read %0d", rd_q.size());
    run_dma(8'h77, 0, 1'b0);

    // random transfers
    for (int r = 0; r < 4; r++) begin
      pad_to(int'($urandom_range(0, 1)));
      run_dma(8'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
